vc_arbiter_demux: RTL and testbench
===================================

Name: vc_arbiter_demux

Overview:
- Transmit-layer stage directly downstream of the VC0/VC1 FIFOs.
- Pops words from the two VC FIFOs with strict priority (VC0 over VC1).
- Steers each popped word to destination FIFO D0 or D1 according to its destination bit.
- Throttles itself on the D0/D1 almost-full flags, and reports idle and per-VC forwarded-word counts to the top-level controller.

Parameters:
- data_width, 6: word width, equal to the VC FIFO width.
- dest_bit, 4: index of the bit in the word that selects the destination (0 -> D0, 1 -> D1).
- cnt_width, 8: width of the per-VC forwarded-word counters.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- init  in  1  enable from the top-level controller; 0 holds the block in IDLE.
- empty_fifo_VC0  in  1  VC0 FIFO empty.
- empty_fifo_VC1  in  1  VC1 FIFO empty.
- data_out_VC0  in  data_width  VC0 read data, valid the cycle after pop_VC0.
- data_out_VC1  in  data_width  VC1 read data, valid the cycle after pop_VC1.
- almost_full_D0  in  1  D0 FIFO almost-full.
- almost_full_D1  in  1  D1 FIFO almost-full.
- pop_VC0  out  1  rd_enable to the VC0 FIFO.
- pop_VC1  out  1  rd_enable to the VC1 FIFO.
- push_D0  out  1  wr_enable to the D0 FIFO.
- push_D1  out  1  wr_enable to the D1 FIFO.
- data_out  out  data_width  write data to D0/D1.
- idle  out  1  no work pending and pipeline empty.
- cnt_VC0  out  cnt_width  words forwarded from VC0.
- cnt_VC1  out  cnt_width  words forwarded from VC1.

Behaviour:
- Reset (reset=0, asynchronous), all outputs cleared:
  - pop_VC0=0, pop_VC1=0, push_D0=0, push_D1=0, data_out=0, cnt_VC0=0, cnt_VC1=0.
  - idle=1, state=IDLE.
  - All pipeline valid bits cleared; in-flight words are discarded, with no push.
- State machine (registered):
  - IDLE: pops forced to 0. Goes to ACTIVE on a clk edge with init=1.
  - ACTIVE: arbitrates. Goes to DRAIN on init=0.
  - DRAIN: no new pops; in-flight words are still pushed. Goes to IDLE once both pipeline valid bits are 0 (at most 2 cycles).
- Stall: stall = almost_full_D0 | almost_full_D1. Backpressure is global, so either destination stalls both VCs.
- Pop logic (combinational, ACTIVE only):
  - pop_VC0 = !empty_fifo_VC0 & !stall.
  - pop_VC1 = empty_fifo_VC0 & !empty_fifo_VC1 & !stall.
  - At most one pop per cycle. VC1 may starve while VC0 is non-empty; this is intended.
- Pipeline:
  - Stage 1 (cycle after a pop): register v1=1 and src1 (0=VC0, 1=VC1).
  - Stage 2 (the following edge): when v1=1, capture word = src1 ? data_out_VC1 : data_out_VC0.
    - data_out <= word.
    - push_D0 <= !word[dest_bit]; push_D1 <= word[dest_bit].
    - Increment cnt_VC0 or cnt_VC1 by source.
  - When v1=0: push_D0 <= 0 and push_D1 <= 0; data_out holds its last value.
  - Latency: pop at edge N -> push asserted after edge N+2. Throughput is 1 word/cycle.
- Skid:
  - Up to 2 words are in flight when stall rises.
  - The D-FIFO almost-full threshold must leave at least 2 free entries.
  - The arbiter never drops or holds an in-flight word. Stall does not affect stages 1 and 2.
- Counters wrap modulo 2^cnt_width; no saturation.
- idle (registered) = (state==IDLE) | (empty_fifo_VC0 & empty_fifo_VC1 & !v1 & !push_D0 & !push_D1).
- Empty with a pop request: a pop is never issued on an empty FIFO, by construction.
- Reset mid-operation: immediate clear, as above. The counters restart at 0.

Decomposition:
- Shared package:
  - State encoding: IDLE=2'b00, ACTIVE=2'b01, DRAIN=2'b10.
  - Constant SRC_VC0=1'b0, SRC_VC1=1'b1.
  - Default data_width and dest_bit, shared with the VC and D FIFOs.
- One natural sub-module, vc_route_stage: stage-2 register, destination decode and counters. The top holds the FSM, pop logic and stage 1.

Test Plan:
1. Reset, then init=1. VC0 holds 0x05 (bit4=0) and 0x12 (bit4=1); VC1 is empty, no stall. Required: pop_VC0 high 2 cycles; push_D0 with data_out=0x05, then push_D1 with 0x12, 2 cycles after each pop; cnt_VC0=2; idle=1 afterwards.
2. Both VCs non-empty: VC0 holds 3 words, VC1 holds 0x21. Required: pop_VC0 for 3 consecutive cycles, then pop_VC1 for 1 cycle; push of 0x21 to D0 last; cnt_VC0=3, cnt_VC1=1.
3. Steady VC0 stream; raise almost_full_D1 for 4 cycles. Required: pop_VC0 drops the same cycle; exactly the 2 in-flight words are pushed; pops resume the cycle after almost_full_D1 falls; no word is lost or duplicated in the scoreboard.
4. With 2 words in flight, drop init. Required: state goes ACTIVE -> DRAIN -> IDLE; both words are pushed; no further pops while init=0.
5. Assert reset low asynchronously between clock edges with 1 word in flight. Required: all outputs go to reset values immediately; no push of the in-flight word; counters read 0.
6. Push 256 VC1 words with cnt_width=8. Required: cnt_VC1 wraps to 0; routing stays correct.

Source files
------------

// File: rtl/vc_arbiter_demux_pkg.sv
// rtl/vc_arbiter_demux_pkg.sv - shared types and defaults for the VC arbiter/demux stage
package vc_arbiter_demux_pkg;

  localparam int DATA_WIDTH = 6;
  localparam int DEST_BIT   = 4;
  localparam int CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_DRAIN  = 2'b10
  } state_e;

  localparam logic SRC_VC0 = 1'b0;
  localparam logic SRC_VC1 = 1'b1;

endpackage

// File: rtl/vc_arbiter_demux_if.sv
// rtl/vc_arbiter_demux_if.sv - VC FIFO / D FIFO / controller signal bundle
interface vc_arbiter_demux_if
  import vc_arbiter_demux_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int CNT_W  = CNT_WIDTH
) ();

  logic              init;
  logic              empty_fifo_VC0;
  logic              empty_fifo_VC1;
  logic [DATA_W-1:0] data_out_VC0;
  logic [DATA_W-1:0] data_out_VC1;
  logic              almost_full_D0;
  logic              almost_full_D1;
  logic              pop_VC0;
  logic              pop_VC1;
  logic              push_D0;
  logic              push_D1;
  logic [DATA_W-1:0] data_out;
  logic              idle;
  logic [CNT_W-1:0]  cnt_VC0;
  logic [CNT_W-1:0]  cnt_VC1;

  // master is the arbiter side; slave is the FIFOs and controller around it
  modport master (
    input  init, empty_fifo_VC0, empty_fifo_VC1, data_out_VC0, data_out_VC1,
    input  almost_full_D0, almost_full_D1,
    output pop_VC0, pop_VC1, push_D0, push_D1, data_out, idle, cnt_VC0, cnt_VC1
  );

  modport slave (
    output init, empty_fifo_VC0, empty_fifo_VC1, data_out_VC0, data_out_VC1,
    output almost_full_D0, almost_full_D1,
    input  pop_VC0, pop_VC1, push_D0, push_D1, data_out, idle, cnt_VC0, cnt_VC1
  );

endinterface

// File: rtl/vc_arbiter_demux_route_stage.sv
// rtl/vc_arbiter_demux_route_stage.sv - stage 2: word capture, destination decode, per-VC counters
module vc_route_stage
  import vc_arbiter_demux_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int dest_bit   = DEST_BIT,
  parameter int cnt_width  = CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_v1,
  input  logic                  i_src1,
  input  logic [data_width-1:0] i_data_vc0,
  input  logic [data_width-1:0] i_data_vc1,
  output logic                  o_push_d0,
  output logic                  o_push_d1,
  output logic [data_width-1:0] o_data,
  output logic [cnt_width-1:0]  o_cnt_vc0,
  output logic [cnt_width-1:0]  o_cnt_vc1
);

  logic [data_width-1:0] w_word;
  logic [data_width-1:0] r_data;
  logic                  r_push_d0;
  logic                  r_push_d1;
  logic [cnt_width-1:0]  r_cnt_vc0;
  logic [cnt_width-1:0]  r_cnt_vc1;

  assign w_word = (i_src1 == SRC_VC1) ? i_data_vc1 : i_data_vc0;

  // Stall never reaches this stage: an in-flight word is always pushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_push_d0 <= 1'b0;
      r_push_d1 <= 1'b0;
      r_cnt_vc0 <= '0;
      r_cnt_vc1 <= '0;
    end else if (i_v1) begin
      r_data    <= w_word;
      r_push_d0 <= ~w_word[dest_bit];
      r_push_d1 <= w_word[dest_bit];
      if (i_src1 == SRC_VC1) begin
        r_cnt_vc1 <= r_cnt_vc1 + cnt_width'(1);
      end else begin
        r_cnt_vc0 <= r_cnt_vc0 + cnt_width'(1);
      end
    end else begin
      r_push_d0 <= 1'b0;
      r_push_d1 <= 1'b0;
    end
  end

  assign o_push_d0 = r_push_d0;
  assign o_push_d1 = r_push_d1;
  assign o_data    = r_data;
  assign o_cnt_vc0 = r_cnt_vc0;
  assign o_cnt_vc1 = r_cnt_vc1;

endmodule

// File: rtl/vc_arbiter_demux.sv
// rtl/vc_arbiter_demux.sv - strict-priority VC0/VC1 arbiter steering words to D0/D1
module vc_arbiter_demux
  import vc_arbiter_demux_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int dest_bit   = DEST_BIT,
  parameter int cnt_width  = CNT_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  vc_arbiter_demux_if.master bus
);

  state_e r_state;
  state_e w_state_nxt;
  logic   w_stall;
  logic   w_pop_vc0;
  logic   w_pop_vc1;
  logic   r_v1;
  logic   r_src1;
  logic   r_idle;
  logic   w_push_d0;
  logic   w_push_d1;
  logic [data_width-1:0] w_data;
  logic [cnt_width-1:0]  w_cnt_vc0;
  logic [cnt_width-1:0]  w_cnt_vc1;

  assign w_stall = bus.almost_full_D0 | bus.almost_full_D1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pops are also gated by init so nothing new leaves the VC FIFOs once it drops.
  always_comb begin
    w_state_nxt = r_state;
    w_pop_vc0   = 1'b0;
    w_pop_vc1   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.init) w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!bus.init) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_pop_vc0 = ~bus.empty_fifo_VC0 & ~w_stall;
          w_pop_vc1 = bus.empty_fifo_VC0 & ~bus.empty_fifo_VC1 & ~w_stall;
        end
      end
      ST_DRAIN: begin
        if (!r_v1 && !w_push_d0 && !w_push_d1) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v1   <= 1'b0;
      r_src1 <= SRC_VC0;
      r_idle <= 1'b1;
    end else begin
      r_v1   <= w_pop_vc0 | w_pop_vc1;
      r_src1 <= w_pop_vc1 ? SRC_VC1 : SRC_VC0;
      r_idle <= (r_state == ST_IDLE) |
                (bus.empty_fifo_VC0 & bus.empty_fifo_VC1 & ~r_v1 & ~w_push_d0 & ~w_push_d1);
    end
  end

  vc_route_stage #(
    .data_width (data_width),
    .dest_bit   (dest_bit),
    .cnt_width  (cnt_width)
  ) u_route (
    .clk        (clk),
    .rst_n      (reset),
    .i_v1       (r_v1),
    .i_src1     (r_src1),
    .i_data_vc0 (bus.data_out_VC0),
    .i_data_vc1 (bus.data_out_VC1),
    .o_push_d0  (w_push_d0),
    .o_push_d1  (w_push_d1),
    .o_data     (w_data),
    .o_cnt_vc0  (w_cnt_vc0),
    .o_cnt_vc1  (w_cnt_vc1)
  );

  assign bus.pop_VC0  = w_pop_vc0;
  assign bus.pop_VC1  = w_pop_vc1;
  assign bus.push_D0  = w_push_d0;
  assign bus.push_D1  = w_push_d1;
  assign bus.data_out = w_data;
  assign bus.idle     = r_idle;
  assign bus.cnt_VC0  = w_cnt_vc0;
  assign bus.cnt_VC1  = w_cnt_vc1;

endmodule

// File: tb/tb_vc_arbiter_demux.sv
// tb/tb_vc_arbiter_demux.sv - scoreboard bench for vc_arbiter_demux with queue-based FIFO models
module tb_vc_arbiter_demux;
  import vc_arbiter_demux_pkg::*;

  typedef struct packed {
    logic       src;
    logic [5:0] w;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vc_arbiter_demux_if bus ();

  vc_arbiter_demux dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  logic [5:0] q0[$];
  logic [5:0] q1[$];
  exp_t sb[$];
  int   pop_trace[$];
  int   mcnt0, mcnt1;
  int   n_pop0, n_pop1, n_push_seen;
  logic last_p0, last_p1;
  exp_t m_e;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every push must match the oldest popped word, in order, with the right destination.
  always @(negedge clk) begin
    if (reset && (bus.push_D0 || bus.push_D1)) begin
      chk("sb_nonempty", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        m_e = sb.pop_front();
        if (m_e.src) mcnt1 = (mcnt1 + 1) % 256;
        else         mcnt0 = (mcnt0 + 1) % 256;
        chk("push_data", int'(bus.data_out), int'(m_e.w));
        chk("push_dest", int'({bus.push_D1, bus.push_D0}), m_e.w[4] ? 2 : 1);
        chk("cnt_vc0", int'(bus.cnt_VC0), mcnt0);
        chk("cnt_vc1", int'(bus.cnt_VC1), mcnt1);
      end
    end
  end

  // One clock of FIFO behaviour; entered and left at a falling edge.
  task automatic step();
    logic [5:0] w;
    #1;
    last_p0 = bus.pop_VC0;
    last_p1 = bus.pop_VC1;
    chk("one_pop", int'(last_p0 && last_p1), 0);
    if (last_p0) chk("pop0_nonempty", int'(q0.size() > 0), 1);
    if (last_p1) chk("pop1_nonempty", int'(q1.size() > 0), 1);
    @(posedge clk);
    @(negedge clk);
    if (bus.push_D0 || bus.push_D1) n_push_seen++;
    if (last_p0 && q0.size() > 0) begin
      w = q0.pop_front();
      bus.data_out_VC0 = w;
      sb.push_back('{src: SRC_VC0, w: w});
      n_pop0++;
      pop_trace.push_back(0);
    end
    if (last_p1 && q1.size() > 0) begin
      w = q1.pop_front();
      bus.data_out_VC1 = w;
      sb.push_back('{src: SRC_VC1, w: w});
      n_pop1++;
      pop_trace.push_back(1);
    end
    bus.empty_fifo_VC0 = (q0.size() == 0);
    bus.empty_fifo_VC1 = (q1.size() == 0);
  endtask

  task automatic load(input int vc, input logic [5:0] w);
    if (vc == 1) q1.push_back(w);
    else         q0.push_back(w);
    bus.empty_fifo_VC0 = (q0.size() == 0);
    bus.empty_fifo_VC1 = (q1.size() == 0);
  endtask

  task automatic clear_model();
    sb.delete(); q0.delete(); q1.delete(); pop_trace.delete();
    mcnt0 = 0; mcnt1 = 0; n_pop0 = 0; n_pop1 = 0; n_push_seen = 0;
    bus.init = 1'b0;
    bus.empty_fifo_VC0 = 1'b1;
    bus.empty_fifo_VC1 = 1'b1;
    bus.almost_full_D0 = 1'b0;
    bus.almost_full_D1 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_model();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (q0.size() + q1.size() + sb.size()) > 0; i++) step();
    repeat (3) step();
    chk("drain_done", q0.size() + q1.size() + sb.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pop0"}, int'(bus.pop_VC0), 0);
    chk({tag, "_pop1"}, int'(bus.pop_VC1), 0);
    chk({tag, "_push"}, int'({bus.push_D1, bus.push_D0}), 0);
    chk({tag, "_data"}, int'(bus.data_out), 0);
    chk({tag, "_cnt0"}, int'(bus.cnt_VC0), 0);
    chk({tag, "_cnt1"}, int'(bus.cnt_VC1), 0);
    chk({tag, "_idle"}, int'(bus.idle), 1);
    chk({tag, "_state"}, int'(dut.r_state), int'(ST_IDLE));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int trace_code;
    bus.data_out_VC0 = '0;
    bus.data_out_VC1 = '0;
    clear_model();
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b1;

    // 1: two VC0 words routed to D0 then D1
    load(0, 6'h05);
    load(0, 6'h12);
    bus.init = 1'b1;
    repeat (6) step();
    chk("t1_pops", n_pop0, 2);
    drain(20);
    chk("t1_cnt0", int'(bus.cnt_VC0), 2);
    chk("t1_idle", int'(bus.idle), 1);

    // 2: strict priority, VC1 only after VC0 empties
    do_reset();
    load(0, 6'h03); load(0, 6'h14); load(0, 6'h2a); load(1, 6'h21);
    bus.init = 1'b1;
    repeat (8) step();
    chk("t2_npops", pop_trace.size(), 4);
    trace_code = 0;
    foreach (pop_trace[i]) trace_code = trace_code * 10 + pop_trace[i] + 1;
    chk("t2_order", trace_code, 1112);
    drain(20);
    chk("t2_cnt0", int'(bus.cnt_VC0), 3);
    chk("t2_cnt1", int'(bus.cnt_VC1), 1);

    // 3: stall in the middle of a steady VC0 stream
    do_reset();
    for (int i = 0; i < 12; i++) load(0, 6'($urandom_range(0, 63)));
    bus.init = 1'b1;
    repeat (4) step();
    base = n_push_seen - int'(bus.push_D0 | bus.push_D1);
    bus.almost_full_D1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_stalled_pop", int'(last_p0), 0);
    end
    chk("t3_inflight", n_push_seen - base, 2);
    bus.almost_full_D1 = 1'b0;
    step();
    chk("t3_resume", int'(last_p0), 1);
    drain(40);

    // 4: drop init with two words in flight
    do_reset();
    for (int i = 0; i < 6; i++) load(0, 6'($urandom_range(0, 63)));
    bus.init = 1'b1;
    repeat (4) step();
    chk("t4_active", int'(dut.r_state), int'(ST_ACTIVE));
    base = n_push_seen - int'(bus.push_D0 | bus.push_D1);
    bus.init = 1'b0;
    step();
    chk("t4_drain", int'(dut.r_state), int'(ST_DRAIN));
    chk("t4_nopop", int'(last_p0 | last_p1), 0);
    repeat (3) begin
      step();
      chk("t4_nopop", int'(last_p0 | last_p1), 0);
    end
    chk("t4_idle_state", int'(dut.r_state), int'(ST_IDLE));
    chk("t4_pushed", n_push_seen - base, 2);
    chk("t4_sb_empty", sb.size(), 0);
    chk("t4_left", q0.size(), 3);

    // 5: asynchronous reset with a word in flight
    do_reset();
    load(0, 6'h07); load(0, 6'h19); load(0, 6'h0c);
    bus.init = 1'b1;
    repeat (3) step();
    chk("t5_cnt_before", int'(bus.cnt_VC0), 1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs("t5");
    chk("t5_v1", int'(dut.r_v1), 0);
    clear_model();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) step();
    chk("t5_no_push", n_push_seen, 0);

    // 6: 256 VC1 words wrap the VC1 counter
    do_reset();
    for (int i = 0; i < 256; i++) load(1, 6'($urandom_range(0, 63)));
    bus.init = 1'b1;
    drain(400);
    chk("t6_cnt1_wrap", int'(bus.cnt_VC1), 0);
    chk("t6_cnt0", int'(bus.cnt_VC0), 0);
    chk("t6_npops", n_pop1, 256);

    // 7: random arrivals and random backpressure
    do_reset();
    bus.init = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) load(int'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
      bus.almost_full_D0 = ($urandom_range(0, 7) == 0);
      bus.almost_full_D1 = ($urandom_range(0, 7) == 0);
      step();
    end
    bus.almost_full_D0 = 1'b0;
    bus.almost_full_D1 = 1'b0;
    drain(200);
    chk("t7_cnt0", int'(bus.cnt_VC0), n_pop0 % 256);
    chk("t7_cnt1", int'(bus.cnt_VC1), n_pop1 % 256);
    chk("t7_idle", int'(bus.idle), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
